// File: rtl/module2_coarse_cfo_autocorr.sv
// module2_coarse_cfo_autocorr
// Streaming lag-DELAY autocorrelator for coarse CFO estimation on the STF.
// Each accepted sample forms r[n]*conj(r[n-DELAY]). A running sum over the
// last WIN products is registered on m_re/m_im behind a one-deep output
// stage with valid/ready handshaking.
// Optional feature macro: COARSE_CFO_AUTOCORR_POWER_EN adds the windowed
// delayed-sample energy on m_pwr. Without it, m_pwr is tied to zero.
// History contents are never cleared. They are zero-masked by the warm-up
// counter until enough samples have been written since reset or clear.
module module2_coarse_cfo_autocorr #(
    parameter int DELAY     = 16,
    parameter int WIN       = 16,
    parameter int ACC_WIDTH = 40
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 clear,
    input  logic [15:0]          s_i,
    input  logic [15:0]          s_q,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [ACC_WIDTH-1:0] m_re,
    output logic [ACC_WIDTH-1:0] m_im,
    output logic [ACC_WIDTH-1:0] m_pwr,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int CNT_W = $clog2(DELAY + WIN + 1);
    localparam int DP_W  = $clog2(DELAY);
    localparam int WP_W  = $clog2(WIN);
    localparam int EXT_W = ACC_WIDTH - 33;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DELAY + WIN);
    localparam logic [CNT_W-1:0] CNT_PROD = CNT_W'(DELAY + WIN - 1);
    localparam logic [CNT_W-1:0] CNT_DLY  = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] CNT_WIN  = CNT_W'(WIN);
    localparam logic [DP_W-1:0]  DP_LAST  = DP_W'(DELAY - 1);
    localparam logic [WP_W-1:0]  WP_LAST  = WP_W'(WIN - 1);

    logic signed [15:0]          dly_i_r [DELAY];
    logic signed [15:0]          dly_q_r [DELAY];
    logic signed [32:0]          pre_hist_r [WIN];
    logic signed [32:0]          pim_hist_r [WIN];
    logic [DP_W-1:0]             dptr_r;
    logic [WP_W-1:0]             wptr_r;
    logic [CNT_W-1:0]            cnt_r;
    logic signed [ACC_WIDTH-1:0] acc_re_r, acc_im_r;
    logic signed [ACC_WIDTH-1:0] acc_re_nxt_s, acc_im_nxt_s;
    logic [ACC_WIDTH-1:0]        m_re_r, m_im_r;
    logic                        m_valid_r;

    logic                        s_ready_s, accept_s, produce_s;
    logic signed [15:0]          si_s, sq_s, di_s, dq_s;
    logic signed [31:0]          m_ii_s, m_qq_s, m_qi_s, m_iq_s;
    logic signed [32:0]          p_re_s, p_im_s, o_re_s, o_im_s;

    // Handshake, delayed-sample fetch, complex product and accumulator update
    always_comb begin
        s_ready_s = !m_valid_r || m_ready;
        accept_s  = s_valid && s_ready_s && !clear;
        produce_s = accept_s && (cnt_r >= CNT_PROD);
        si_s      = $signed(s_i);
        sq_s      = $signed(s_q);
        if (cnt_r >= CNT_DLY) begin
            di_s = dly_i_r[dptr_r];
            dq_s = dly_q_r[dptr_r];
        end else begin
            di_s = 16'sd0;
            dq_s = 16'sd0;
        end
        m_ii_s = 32'(si_s) * 32'(di_s);
        m_qq_s = 32'(sq_s) * 32'(dq_s);
        m_qi_s = 32'(sq_s) * 32'(di_s);
        m_iq_s = 32'(si_s) * 32'(dq_s);
        p_re_s = 33'(m_ii_s) + 33'(m_qq_s);
        p_im_s = 33'(m_qi_s) - 33'(m_iq_s);
        if (cnt_r >= CNT_WIN) begin
            o_re_s = pre_hist_r[wptr_r];
            o_im_s = pim_hist_r[wptr_r];
        end else begin
            o_re_s = 33'sd0;
            o_im_s = 33'sd0;
        end
        acc_re_nxt_s = acc_re_r + {{EXT_W{p_re_s[32]}}, p_re_s}
                                - {{EXT_W{o_re_s[32]}}, o_re_s};
        acc_im_nxt_s = acc_im_r + {{EXT_W{p_im_s[32]}}, p_im_s}
                                - {{EXT_W{o_im_s[32]}}, o_im_s};
    end

    // Control state: pointers, warm-up counter, accumulators, output stage
    always_ff @(posedge ap_clk) begin
        if (ap_rst || clear) begin
            dptr_r    <= DP_W'(0);
            wptr_r    <= WP_W'(0);
            cnt_r     <= CNT_W'(0);
            acc_re_r  <= {ACC_WIDTH{1'b0}};
            acc_im_r  <= {ACC_WIDTH{1'b0}};
            m_re_r    <= {ACC_WIDTH{1'b0}};
            m_im_r    <= {ACC_WIDTH{1'b0}};
            m_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                dptr_r   <= (dptr_r == DP_LAST) ? DP_W'(0) : dptr_r + DP_W'(1);
                wptr_r   <= (wptr_r == WP_LAST) ? WP_W'(0) : wptr_r + WP_W'(1);
                cnt_r    <= (cnt_r == CNT_FULL) ? cnt_r : cnt_r + CNT_W'(1);
                acc_re_r <= acc_re_nxt_s;
                acc_im_r <= acc_im_nxt_s;
            end
            if (produce_s) begin
                m_re_r    <= acc_re_nxt_s;
                m_im_r    <= acc_im_nxt_s;
                m_valid_r <= 1'b1;
            end else if (m_valid_r && m_ready) begin
                m_valid_r <= 1'b0;
            end
        end
    end

    // Sample and product history storage, written at the current pointers
    always_ff @(posedge ap_clk) begin
        if (accept_s && !ap_rst) begin
            dly_i_r[dptr_r]    <= si_s;
            dly_q_r[dptr_r]    <= sq_s;
            pre_hist_r[wptr_r] <= p_re_s;
            pim_hist_r[wptr_r] <= p_im_s;
        end
    end

`ifdef COARSE_CFO_AUTOCORR_POWER_EN
    logic signed [32:0]          pwr_hist_r [WIN];
    logic signed [31:0]          m_di2_s, m_dq2_s;
    logic signed [32:0]          p_pwr_s, o_pwr_s;
    logic signed [ACC_WIDTH-1:0] acc_pwr_r, acc_pwr_nxt_s;
    logic [ACC_WIDTH-1:0]        m_pwr_r;

    // Energy of the delayed sample and windowed energy update
    always_comb begin
        m_di2_s = 32'(di_s) * 32'(di_s);
        m_dq2_s = 32'(dq_s) * 32'(dq_s);
        p_pwr_s = 33'(m_di2_s) + 33'(m_dq2_s);
        if (cnt_r >= CNT_WIN) begin
            o_pwr_s = pwr_hist_r[wptr_r];
        end else begin
            o_pwr_s = 33'sd0;
        end
        acc_pwr_nxt_s = acc_pwr_r + {{EXT_W{p_pwr_s[32]}}, p_pwr_s}
                                  - {{EXT_W{o_pwr_s[32]}}, o_pwr_s};
    end

    // Energy accumulator and its output register, same rules as m_re/m_im
    always_ff @(posedge ap_clk) begin
        if (ap_rst || clear) begin
            acc_pwr_r <= {ACC_WIDTH{1'b0}};
            m_pwr_r   <= {ACC_WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                acc_pwr_r <= acc_pwr_nxt_s;
            end
            if (produce_s) begin
                m_pwr_r <= acc_pwr_nxt_s;
            end
        end
    end

    // Energy history storage
    always_ff @(posedge ap_clk) begin
        if (accept_s && !ap_rst) begin
            pwr_hist_r[wptr_r] <= p_pwr_s;
        end
    end

    assign m_pwr = m_pwr_r;
`else
    assign m_pwr = {ACC_WIDTH{1'b0}};
`endif

    assign s_ready = s_ready_s;
    assign m_valid = m_valid_r;
    assign m_re    = m_re_r;
    assign m_im    = m_im_r;

endmodule

// File: tb/tb_module2_coarse_cfo_autocorr.sv
// Self-checking bench for module2_coarse_cfo_autocorr (DELAY = WIN = 16).
// The reference model keeps every sample accepted since the last reset or
// clear. For each producing accept it recomputes the window sum directly.
// The DUT output stage is modelled as a queue of pending results.
module tb_module2_coarse_cfo_autocorr;
    localparam int DELAY = 16;
    localparam int WIN   = 16;
    localparam int AW    = 40;

    logic          ap_clk = 1'b0;
    logic          ap_rst, clear, s_valid, s_ready, m_valid, m_ready;
    logic [15:0]   s_i, s_q;
    logic [AW-1:0] m_re, m_im, m_pwr;

    module2_coarse_cfo_autocorr #(.DELAY(DELAY), .WIN(WIN), .ACC_WIDTH(AW)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .clear(clear),
        .s_i(s_i), .s_q(s_q), .s_valid(s_valid), .s_ready(s_ready),
        .m_re(m_re), .m_im(m_im), .m_pwr(m_pwr),
        .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 ap_clk = ~ap_clk;

    int     n_chk = 0, n_err = 0;
    int     hist_i[$], hist_q[$];
    longint exp_re[$], exp_im[$], exp_pw[$];
    int     prod_cnt = 0, nready_cnt = 0;
    bit     mon_en = 1'b0;
    int     lit_mode = 0;
    longint lit_re, lit_im, lit_pw;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sx(input logic [AW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic int phasor(input int n, input bit q);
        real a, x;
        a = 3.14159265358979 * real'(n) / 32.0;
        x = q ? 8000.0 * $sin(a) : 8000.0 * $cos(a);
        return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
    endfunction

    // Reference model: check outputs, then predict the effect of the coming edge
    always @(negedge ap_clk) begin
        int     n, di, dq, si, sq;
        longint re, im, pw;
        bit     rdy;
        if (mon_en) begin
            rdy = (exp_re.size() == 0) || m_ready;
            chk("s_ready", longint'(s_ready), longint'(rdy));
            chk("m_valid", longint'(m_valid), longint'(exp_re.size() != 0));
            if (!s_ready) nready_cnt++;
            if (m_valid && exp_re.size() != 0) begin
                chk("m_re", sx(m_re), exp_re[0]);
                chk("m_im", sx(m_im), exp_im[0]);
                chk("m_pwr", sx(m_pwr), exp_pw[0]);
                if (m_ready && lit_mode == 1) begin
                    chk("lit_re", sx(m_re), lit_re);
                    chk("lit_im", sx(m_im), lit_im);
                    chk("lit_pwr", sx(m_pwr), lit_pw);
                end
                if (m_ready && lit_mode == 2) begin
                    chk("phasor_im_tol", longint'(sx(m_im) >= 64'sd1022976000 &&
                                                  sx(m_im) <= 64'sd1025024000), 64'sd1);
                    chk("phasor_re_tol", longint'(sx(m_re) >= -64'sd1024000 &&
                                                  sx(m_re) <= 64'sd1024000), 64'sd1);
                end
            end
            if (ap_rst || clear) begin
                hist_i.delete(); hist_q.delete();
                exp_re.delete(); exp_im.delete(); exp_pw.delete();
            end else begin
                if (exp_re.size() != 0 && m_ready) begin
                    void'(exp_re.pop_front()); void'(exp_im.pop_front());
                    void'(exp_pw.pop_front());
                end
                if (s_valid && rdy) begin
                    hist_i.push_back(int'($signed(s_i)));
                    hist_q.push_back(int'($signed(s_q)));
                    n = hist_i.size();
                    if (n >= DELAY + WIN) begin
                        re = 0; im = 0; pw = 0;
                        for (int k = n - WIN; k < n; k++) begin
                            si = hist_i[k]; sq = hist_q[k];
                            di = (k >= DELAY) ? hist_i[k - DELAY] : 0;
                            dq = (k >= DELAY) ? hist_q[k - DELAY] : 0;
                            re += longint'(si) * di + longint'(sq) * dq;
                            im += longint'(sq) * di - longint'(si) * dq;
                            pw += longint'(di) * di + longint'(dq) * dq;
                        end
`ifndef COARSE_CFO_AUTOCORR_POWER_EN
                        pw = 0;
`endif
                        exp_re.push_back(re); exp_im.push_back(im); exp_pw.push_back(pw);
                        prod_cnt++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; s_valid = 1'b1; s_i = 16'h1234; s_q = 16'h4321;
        step();
        clear = 1'b0; s_valid = 1'b0;
    endtask

    // Streams n accepts; kind 0 constant, 1 phasor, else random samples
    task automatic run(input int n, input int kind, input int ci, input int cq, input bit stall);
        int budget, stall_left, base, idx, vi, vq;
        budget = 0; stall_left = stall ? 5 : 0; base = prod_cnt;
        while (hist_i.size() < n && budget < 4 * n + 100) begin
            idx = hist_i.size();
            case (kind)
                0:       begin vi = ci; vq = cq; end
                1:       begin vi = phasor(idx, 1'b0); vq = phasor(idx, 1'b1); end
                default: begin vi = int'($urandom); vq = int'($urandom); end
            endcase
            s_i = 16'(vi); s_q = 16'(vq); s_valid = 1'b1;
            if (stall_left > 0 && m_valid && (prod_cnt - base) == 3) begin
                m_ready = 1'b0; stall_left--;
            end else begin
                m_ready = 1'b1;
            end
            step(); budget++;
        end
        if (hist_i.size() < n) chk("run_budget", longint'(hist_i.size()), longint'(n));
        s_valid = 1'b0; m_ready = 1'b1;
        step(); step();
    endtask

    initial begin
        int     base, nr;
        longint pw_const, pw_clr, pw_ext;
`ifdef COARSE_CFO_AUTOCORR_POWER_EN
        pw_const = 64'sd16000000; pw_clr = 64'sd5440000; pw_ext = 64'sd34359738368;
`else
        pw_const = 64'sd0; pw_clr = 64'sd0; pw_ext = 64'sd0;
`endif
        ap_rst = 1'b1; clear = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        s_i = 16'h0000; s_q = 16'h0000;
        step(); step();
        ap_rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_m_valid", longint'(m_valid), 64'sd0);
        chk("rst_s_ready", longint'(s_ready), 64'sd1);
        chk("rst_m_re", sx(m_re), 64'sd0);
        chk("rst_m_im", sx(m_im), 64'sd0);
        chk("rst_m_pwr", sx(m_pwr), 64'sd0);

        // Constant input (1000, 0)
        lit_mode = 1; lit_re = 64'sd16000000; lit_im = 64'sd0; lit_pw = pw_const;
        base = prod_cnt; nr = nready_cnt;
        run(40, 0, 1000, 0, 1'b0);
        chk("const_outputs", longint'(prod_cnt - base), 64'sd9);
        chk("const_stalls", longint'(nready_cnt - nr), 64'sd0);

        // Same stimulus with a 5-cycle stall at output 3
        do_clear();
        base = prod_cnt; nr = nready_cnt;
        run(40, 0, 1000, 0, 1'b1);
        chk("bp_outputs", longint'(prod_cnt - base), 64'sd9);
        chk("bp_stalls", longint'(nready_cnt - nr), 64'sd5);

        // Rotating phasor
        do_clear();
        lit_mode = 2; base = prod_cnt;
        run(64, 1, 0, 0, 1'b0);
        chk("phasor_outputs", longint'(prod_cnt - base), 64'sd33);

        // clear after 20 accepts, then 32 samples of (-500, 300)
        do_clear();
        lit_mode = 0;
        run(20, 0, 1000, 0, 1'b0);
        do_clear();
        lit_mode = 1; lit_re = 64'sd5440000; lit_im = 64'sd0; lit_pw = pw_clr;
        base = prod_cnt;
        run(32, 0, -500, 300, 1'b0);
        chk("clr_outputs", longint'(prod_cnt - base), 64'sd1);

        // Extremes (-32768, -32768)
        do_clear();
        lit_re = 64'sd34359738368; lit_im = 64'sd0; lit_pw = pw_ext;
        base = prod_cnt;
        run(40, 0, -32768, -32768, 1'b0);
        chk("ext_outputs", longint'(prod_cnt - base), 64'sd9);

        // ap_rst while a result is pending
        do_clear();
        lit_re = 64'sd16000000; lit_im = 64'sd0; lit_pw = pw_const;
        run(34, 0, 1000, 0, 1'b0);
        s_i = 16'd1000; s_q = 16'd0; s_valid = 1'b1; m_ready = 1'b0;
        step();
        chk("pre_rst_valid", longint'(m_valid), 64'sd1);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0; s_valid = 1'b0;
        chk("post_rst_valid", longint'(m_valid), 64'sd0);
        chk("post_rst_ready", longint'(s_ready), 64'sd1);
        m_ready = 1'b1;
        base = prod_cnt;
        run(32, 0, 1000, 0, 1'b0);
        chk("rst_outputs", longint'(prod_cnt - base), 64'sd1);

        // Random traffic, backpressure and occasional clears
        lit_mode = 0;
        for (int c = 0; c < 1500; c++) begin
            s_valid = ($urandom % 4) != 0;
            m_ready = ($urandom % 4) != 0;
            clear   = ($urandom % 97) == 0;
            s_i = (($urandom % 8) == 0) ? 16'h8000 : 16'($urandom);
            s_q = (($urandom % 8) == 0) ? 16'h8000 : 16'($urandom);
            step();
        end
        clear = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        step(); step(); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/module2_coarse_cfo_autocorr.md
# module2_coarse_cfo_autocorr

Streaming delayed autocorrelator for coarse carrier-frequency-offset estimation. It runs on the 802.11 short-training-field sample stream. For each accepted sample it forms the lag-DELAY complex product r[n]·conj(r[n−DELAY]) with signed 16×16 multiplies, and keeps a running sum of that product over the last WIN samples. The windowed correlation goes to the downstream phase/angle stage of module2_coarse_cfo, which turns it into the CFO estimate.

## Interface
- DELAY, 16: autocorrelation lag in samples (STF period), 2..64
- WIN, 16: correlation window length in samples, power of two, 2..64
- ACC_WIDTH, 40: width of accumulators and outputs; must be ≥ 33 + log2(WIN)
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  reset, synchronous, active-high
- clear  in  1  restart warm-up; sampled only when high, overrides s_valid in the same cycle
- s_i, s_q  in  16 each  input sample, signed two's complement
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- m_re, m_im  out  ACC_WIDTH each  windowed correlation, signed
- m_pwr  out  ACC_WIDTH  windowed energy Σ(i²+q²) of the delayed samples (see Configuration)
- m_valid  out  1  output register holds an unconsumed result
- m_ready  in  1  downstream accepts the result

## Operation
- Accept: a sample is accepted when s_valid && s_ready && !clear. Define s_ready = !m_valid || m_ready, so the output register is a single skid-less stage.
- Sample history: circular buffer DELAY deep. d = sample accepted DELAY accepts earlier. d = 0 while fewer than DELAY samples have been accepted since reset/clear.
- Products, full precision, 33-bit signed:
  - p_re = s_i·d_i + s_q·d_q
  - p_im = s_q·d_i − s_i·d_q
- Product history: circular buffer WIN deep holding p_re and p_im. o = product from WIN accepts earlier. o = 0 while fewer than WIN samples have been accepted.
- Accumulate on every accept: acc_re += p_re − o_re and acc_im += p_im − o_im. Both are sign-extended to ACC_WIDTH; no saturation, because the width rule guarantees no overflow.
- Warm-up counter: counts accepts and saturates at DELAY+WIN. An accept produces output only when the pre-increment count ≥ DELAY+WIN−1, i.e. the (DELAY+WIN)th accepted sample is the first to produce a result. Earlier accepts update state but never assert m_valid.
- Output register: on a producing accept, load the post-update acc into m_re/m_im and set m_valid. Clear m_valid on m_valid && m_ready when no new producing accept happens in the same cycle. A simultaneous consume and produce keeps m_valid = 1 with the new data.
- clear:
  - zeroes the accumulators, the warm-up counter, both buffer pointers and the history contents (or the equivalent zero-masking), and m_valid
  - the sample presented in that cycle is dropped
- ap_rst: same effect as clear.
- m_re/m_im/m_pwr must hold stable while m_valid && !m_ready.

## Timing
- Reset values: s_ready = 1, m_valid = 0, m_re = m_im = m_pwr = 0, all accumulators and counters 0.
- Latency: a producing accept at edge t makes its result visible on m_* with m_valid = 1 right after edge t (one register).
- Throughput: one sample per cycle while m_ready is held high.
- Backpressure: while m_valid && !m_ready, s_ready = 0 combinationally. No internal state changes and no samples are lost.
- clear/ap_rst mid-stream: the next output needs DELAY+WIN fresh accepts. A pending unconsumed result is discarded.
- Pointer wrap: indices wrap modulo DELAY and modulo WIN. There are no gaps at the wrap boundary.

## Configuration
- COARSE_CFO_AUTOCORR_POWER_EN defined:
  - adds a third accumulator acc_pwr += (d_i²+d_q²) − o_pwr, with its own WIN-deep history
  - m_pwr is registered alongside m_re/m_im under the same valid and warm-up rules
- Undefined: no power datapath or history is built, and m_pwr is tied to 0.

## Test plan
- Constant input, DELAY = WIN = 16: s = (1000, 0) for 40 cycles with m_ready = 1.
  - first m_valid comes right after the 32nd accept
  - m_re = 16,000,000 and m_im = 0 on every output through accept 40
  - with POWER_EN, m_pwr = 16,000,000
- Rotating phasor: s = 8000·e^{jπn/32}, rounded.
  - steady-state m_re ≈ 16·64e6·cos(π/2) ≈ 0
  - m_im ≈ +1.024e9, within ±0.1%
- Backpressure: same stimulus as the constant-input test, with m_ready low for 5 cycles at output 3.
  - s_ready is 0 for exactly those cycles
  - m_re is held stable
  - output count and values are identical to the no-stall run
- clear after 20 accepts, then 32 more samples of (−500, 300).
  - no output before the 32nd post-clear accept
  - then m_re = 16·(250000+90000) = 5,440,000 and m_im = 0
- Extremes: s = (−32768, −32768) for 40 samples.
  - m_re = 16·2·2^30 = 2^35 exactly, no wrap at ACC_WIDTH = 40
  - m_im = 0
- ap_rst asserted mid-stream with m_valid = 1: on the next cycle m_valid = 0 and s_ready = 1; outputs resume only after 32 new accepts.
